// File: rtl/regfile_2w2r_pkg.sv
// Shared constants for the 2R2W register file: default geometry and the
// clear-sweep FSM state encoding.
package regfile_2w2r_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;

    // Sweep-clear FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sweep-clear controller: walks a pointer over every entry, one per cycle,
// and flags busy while walking plus a one-cycle done once the last entry is cleared.
module regfile_clr_fsm
    import regfile_2w2r_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;

    // Next-state: clr is only honoured in IDLE; the pointer parks at 0 on exit
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_CLEAR);
    assign done = done_q;
    assign ptr  = ptr_q;

endmodule

// File: rtl/regfile_2w2r.sv
// Two-read / two-write CPU register file with optional registered reads,
// write-to-read bypass, hardwired-zero R0 and a multi-cycle sweep clear.
module regfile_2w2r
    import regfile_2w2r_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] aa,
    input  logic [ADDR_W-1:0] ab,
    output logic [DATA_W-1:0] ra,
    output logic [DATA_W-1:0] rb,
    input  logic              wr,
    input  logic [ADDR_W-1:0] ad,
    input  logic [DATA_W-1:0] rd,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] ad1,
    input  logic [DATA_W-1:0] rd1,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic              wcol
);

    localparam int   DEPTH = 2 ** ADDR_W;
    localparam logic ZR0   = (ZERO_R0 != 0);
    localparam logic BYP   = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] sw_ptr;
    logic              idle;
    logic              we0, we1;
    logic              wcol_q, wcol_d;
    logic [DATA_W-1:0] ra_d, rb_d;

    regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .busy  (busy),
        .done  (done),
        .ptr   (sw_ptr)
    );

    assign idle = ~busy;

    // Effective write enables: dropped while sweeping, and R0 is read-only when hardwired
    assign we0 = wr  & idle & ~(ZR0 && (ad  == '0));
    assign we1 = wr1 & idle & ~(ZR0 && (ad1 == '0));

    // Storage next-state: sweep clears one entry; port 1 is applied first so port 0 wins collisions
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (busy && !(ZR0 && (sw_ptr == '0))) mem_d[sw_ptr] = '0;
        if (we1) mem_d[ad1] = rd1;
        if (we0) mem_d[ad]  = rd;
    end

    // Storage array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    // Same-address double write is flagged the cycle after it happens
    always_comb begin
        wcol_d = idle & wr & wr1 & (ad == ad1);
    end

    // Collision flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcol_q <= 1'b0;
        else        wcol_q <= wcol_d;
    end

    assign wcol = wcol_q;

    // Port A read: R0 forced to zero, else bypass from an in-flight write (port 0 first), else storage
    always_comb begin
        ra_d = mem_q[aa];
        if (ZR0 && (aa == '0)) begin
            ra_d = '0;
        end else if (BYP && idle) begin
            if (we0 && (ad == aa))       ra_d = rd;
            else if (we1 && (ad1 == aa)) ra_d = rd1;
        end
    end

    // Port B read: same selection as port A
    always_comb begin
        rb_d = mem_q[ab];
        if (ZR0 && (ab == '0)) begin
            rb_d = '0;
        end else if (BYP && idle) begin
            if (we0 && (ad == ab))       rb_d = rd;
            else if (we1 && (ad1 == ab)) rb_d = rd1;
        end
    end

    generate
        if (READ_REG != 0) begin : g_rreg
            logic [DATA_W-1:0] ra_q, rb_q;

            // Registered reads capture the selected (possibly bypassed) value
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end

            assign ra = ra_q;
            assign rb = rb_q;
        end else begin : g_rcomb
            assign ra = ra_d;
            assign rb = rb_d;
        end
    endgenerate

endmodule
